// File: rtl/team_03_wb_master.sv
// team_03_wb_master: single-transfer Wishbone classic master.
// A core request is latched in IDLE, driven on the bus in BUS until ACK_I,
// and completion is reported with a one-cycle done_o pulse in DONE.
// Optional feature macro: TEAM_03_WBM_TIMEOUT_EN adds a BUS-state timeout
// counter that ends an unacknowledged cycle with err_o=1.
module team_03_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_i,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic [3:0]  req_sel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        cyc;
    logic        timeout_hit;

    // Reject out-of-range timeout settings when the design is elaborated.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

`ifdef TEAM_03_WBM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;

    // Count unacknowledged BUS cycles; held at zero in IDLE so each BUS entry starts fresh.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_cnt <= 16'd0;
        end else if (state != BUS) begin
            tmo_cnt <= 16'd0;
        end else if (!ACK_I && !timeout_hit) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == BUS) && !ACK_I && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the state-derived handshake outputs.
    always_comb begin
        state_next = state;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        cyc        = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (req_i) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                cyc = 1'b1;
                if (ACK_I || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request on acceptance and capture the result when BUS ends.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_i) begin
                we_q  <= req_we_i;
                adr_q <= req_adr_i;
                dat_q <= req_dat_i;
                sel_q <= req_sel_i;
            end
            if (state == BUS && ACK_I) begin
                err_q <= 1'b0;
                if (!we_q) begin
                    rdata_q <= DAT_I;
                end
            end else if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= 32'd0;
            end
        end
    end

    assign CYC_O   = cyc;
    assign STB_O   = cyc;
    assign ADR_O   = cyc ? adr_q : 32'd0;
    assign DAT_O   = cyc ? dat_q : 32'd0;
    assign SEL_O   = cyc ? sel_q : 4'd0;
    assign WE_O    = cyc & we_q;
    assign err_o   = done_o & err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_team_03_wb_master.sv
// tb_team_03_wb_master: randomized transactions against a transaction-level
// model of the master; the slave side is played by the bench itself.
module tb_team_03_wb_master;

    localparam int TMO = 4;
`ifdef TEAM_03_WBM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        req_i;
    logic        req_we_i;
    logic [31:0] req_adr_i;
    logic [31:0] req_dat_i;
    logic [3:0]  req_sel_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    int          vec_count   = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'd0;

    team_03_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req_i     (req_i),
        .req_we_i  (req_we_i),
        .req_adr_i (req_adr_i),
        .req_dat_i (req_dat_i),
        .req_sel_i (req_sel_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .rdata_o   (rdata_o),
        .ADR_O     (ADR_O),
        .DAT_O     (DAT_O),
        .SEL_O     (SEL_O),
        .WE_O      (WE_O),
        .STB_O     (STB_O),
        .CYC_O     (CYC_O),
        .DAT_I     (DAT_I),
        .ACK_I     (ACK_I)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Idle cycles with req_i low; ACK_I noise outside BUS must be ignored.
    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            req_i = 1'b0;
            ACK_I = 1'($urandom);
            DAT_I = $urandom;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            checkOutput("idle_flags", 32'({busy_o, done_o, err_o, CYC_O, STB_O}), 32'd0);
            checkOutput("idle_rdata", rdata_o, model_rdata);
        end
        ACK_I = 1'b0;
    endtask

    // One transaction; called at a negedge with the master idle, returns likewise.
    // ack_delay = STB cycle index (0-based) carrying ACK_I; reset_at = STB cycle
    // index on which reset is raised (-1 for none).
    task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int ack_delay,
                                 input logic [31:0] ack_dat, input int reset_at, input bit hold_req);
        bit timed_out;
        int last_cycle;
        checkOutput("pre_idle", 32'({busy_o, done_o, CYC_O, STB_O}), 32'd0);
        checkOutput("pre_rdata", rdata_o, model_rdata);
        req_i     = 1'b1;
        req_we_i  = we;
        req_adr_i = adr;
        req_dat_i = dat;
        req_sel_i = sel;
        ACK_I     = 1'b0;
        timed_out  = TMO_EN && (ack_delay > TMO - 1);
        last_cycle = timed_out ? TMO - 1 : ack_delay;
        @(posedge wb_clk_i);
        for (int i = 0; i <= last_cycle; i++) begin
            @(negedge wb_clk_i);
            checkOutput("bus_flags", 32'({CYC_O, STB_O, busy_o, done_o, err_o}), 32'(5'b11100));
            checkOutput("bus_adr", ADR_O, adr);
            checkOutput("bus_dat", DAT_O, dat);
            checkOutput("bus_we_sel", 32'({WE_O, SEL_O}), 32'({we, sel}));
            req_i     = hold_req ? 1'b1 : 1'($urandom);
            req_we_i  = 1'($urandom);
            req_adr_i = $urandom;
            req_dat_i = $urandom;
            req_sel_i = 4'($urandom);
            if (i == reset_at) begin
                wb_rst_i = 1'b1;
                ACK_I    = 1'($urandom);
                @(posedge wb_clk_i);
                @(negedge wb_clk_i);
                model_rdata = 32'd0;
                checkOutput("rst_flags", 32'({busy_o, done_o, err_o, CYC_O, STB_O, WE_O, SEL_O}), 32'd0);
                checkOutput("rst_adr_dat", ADR_O | DAT_O, 32'd0);
                checkOutput("rst_rdata", rdata_o, 32'd0);
                wb_rst_i = 1'b0;
                req_i    = 1'b0;
                ACK_I    = 1'b0;
                idleCycles(1);
                return;
            end
            ACK_I = (i == ack_delay);
            DAT_I = (i == ack_delay) ? ack_dat : $urandom;
            if (i == ack_delay && !we) begin
                model_rdata = ack_dat;
            end
            @(posedge wb_clk_i);
        end
        if (timed_out) begin
            model_rdata = 32'd0;
        end
        @(negedge wb_clk_i);
        checkOutput("done_flags", 32'({busy_o, done_o, err_o, CYC_O, STB_O}), 32'({1'b1, 1'b1, timed_out, 2'b00}));
        checkOutput("done_bus_zero", 32'({WE_O, SEL_O}) | ADR_O | DAT_O, 32'd0);
        checkOutput("done_rdata", rdata_o, model_rdata);
        ACK_I = 1'($urandom);
        DAT_I = $urandom;
        req_i = hold_req ? 1'b1 : 1'($urandom);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        ACK_I = 1'b0;
        req_i = hold_req;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wb_rst_i  = 1'b1;
        req_i     = 1'b1;
        req_we_i  = 1'b0;
        req_adr_i = 32'hFFFF_FFFF;
        req_dat_i = 32'hFFFF_FFFF;
        req_sel_i = 4'hF;
        DAT_I     = 32'hFFFF_FFFF;
        ACK_I     = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("reset_flags", 32'({busy_o, done_o, err_o, CYC_O, STB_O, WE_O, SEL_O}), 32'd0);
        checkOutput("reset_adr_dat", ADR_O | DAT_O, 32'd0);
        checkOutput("reset_rdata", rdata_o, 32'd0);
        wb_rst_i = 1'b0;
        req_i    = 1'b0;
        ACK_I    = 1'b0;
        idleCycles(2);

        // Read acknowledged two cycles after the first strobe.
        applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, -1, 1'b0);
        idleCycles(1);
        // Write acknowledged on the first strobe cycle; rdata stays.
        applyStimulus(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 0, 32'hCAFE_F00D, -1, 1'b0);
        idleCycles(1);
        // Back-to-back with req_i held high.
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 4'hF, 1, 32'h1111_2222, -1, 1'b1);
        applyStimulus(1'b0, 32'h0000_1004, 32'h0, 4'hF, 0, 32'h3333_4444, -1, 1'b1);
        applyStimulus(1'b1, 32'h0000_1008, 32'h5555_6666, 4'hC, 1, 32'h0, -1, 1'b0);
        idleCycles(1);
        // No acknowledge for a long time, then acknowledge on the last allowed cycle.
        applyStimulus(1'b0, 32'h0000_2000, 32'h0, 4'hF, 10, 32'h7777_8888, -1, 1'b0);
        applyStimulus(1'b0, 32'h0000_2004, 32'h0, 4'hF, TMO - 1, 32'h9999_AAAA, -1, 1'b0);
        // Reset on the third strobe cycle, then a normal request.
        applyStimulus(1'b0, 32'h0000_3000, 32'h0, 4'hF, 6, 32'hBBBB_CCCC, 2, 1'b0);
        applyStimulus(1'b0, 32'h0000_3004, 32'h0, 4'hF, 1, 32'hDDDD_EEEE, -1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            applyStimulus(1'($urandom), $urandom, $urandom, 4'($urandom),
                          $urandom_range(0, 6), $urandom, -1, 1'($urandom));
            if (!req_i) begin
                idleCycles($urandom_range(0, 2));
            end
        end
        req_i = 1'b0;
        idleCycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/team_03_wb_master.md
TEAM_03_WB_MASTER -- requirements
Module: team_03_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUS-state cycles to wait for ACK_I (range 1..65535).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_i, input, 1 bit: core request strobe, sampled only in IDLE.
REQ-005 SHALL have port req_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have ports req_adr_i and req_dat_i, inputs, 32 bits each: request address and write data.
REQ-007 SHALL have port req_sel_i, input, 4 bits: byte lane enables.
REQ-008 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port err_o, output, 1 bit: timeout flag, valid while done_o is high.
REQ-011 SHALL have port rdata_o, output, 32 bits: read data, held until the next completion.
REQ-012 SHALL have ports ADR_O, DAT_O, SEL_O, WE_O, STB_O and CYC_O, outputs, widths 32/32/4/1/1/1: Wishbone classic master.
REQ-013 SHALL have ports DAT_I, input, 32 bits, and ACK_I, input, 1 bit: Wishbone slave response.

Function
REQ-014 SHALL implement a three-state FSM: IDLE -> BUS -> DONE -> IDLE.
REQ-015 In IDLE with req_i=1, SHALL latch we/adr/dat/sel and enter BUS on the next edge; CYC_O=STB_O=1 from that cycle.
REQ-016 SHALL hold ADR_O, DAT_O, SEL_O and WE_O constant while CYC_O=1, and drive them to 0 when CYC_O=0.
REQ-017 In BUS with ACK_I=1, SHALL enter DONE on the next edge, deassert CYC_O/STB_O, and capture DAT_I into rdata_o for reads; writes leave rdata_o unchanged.
REQ-018 DONE SHALL last exactly one cycle with done_o=1, CYC_O=STB_O=0, then return to IDLE.
REQ-019 Latency SHALL be: req_i accepted at cycle 0, STB_O high at cycle 1, ACK_I at cycle k (k>=1), done_o at cycle k+1; next request acceptable at cycle k+2.
REQ-020 SHALL ignore req_i outside IDLE and ACK_I outside BUS; no request queuing.
REQ-021 SHALL treat DAT_I as don't-care for writes.

Reset
REQ-022 With wb_rst_i=1 at a clock edge, SHALL enter IDLE and set all outputs to 0 (including rdata_o, err_o and the timeout counter), overriding req_i and ACK_I.
REQ-023 Reset during BUS SHALL drop CYC_O/STB_O at that edge and produce no done_o pulse.

Configuration
REQ-024 Macro TEAM_03_WBM_TIMEOUT_EN defined: a 16-bit counter SHALL clear on BUS entry and increment each BUS cycle without ACK_I.
REQ-025 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 without ACK_I, SHALL enter DONE with err_o=1 and rdata_o=0; ACK_I in that same cycle wins (err_o=0).
REQ-026 Macro undefined: no counter is built, err_o SHALL be tied to 0, and BUS SHALL wait indefinitely for ACK_I.

Verification
REQ-027 Read: req_we_i=0, req_adr_i=0x3000_0010, slave acks 2 cycles after STB_O with DAT_I=0xDEADBEEF -> done_o pulses once, rdata_o=0xDEADBEEF, err_o=0, CYC_O low in the DONE cycle.
REQ-028 Write: req_we_i=1, req_dat_i=0x1234_5678, req_sel_i=4'b0011, ack same cycle as first STB_O -> DAT_O/SEL_O stable while CYC_O=1, done_o at cycle 2, rdata_o unchanged.
REQ-029 Back-to-back: req_i held high across two transactions -> second STB_O rises exactly 2 cycles after first done_o; req_i during BUS/DONE ignored.
REQ-030 Timeout (macro on, TIMEOUT_CYCLES=4), no ACK_I -> STB_O high 4 cycles, then done_o=1 with err_o=1 and rdata_o=0; ACK_I on 4th cycle -> err_o=0.
REQ-031 Reset in BUS: assert wb_rst_i on the 3rd STB_O cycle -> all outputs 0 at the next edge, no done_o, new request accepted normally after release.
